// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit:
// funct3 codes, response error codes and FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] ERR_OK     = 2'b00;
   localparam logic [1:0] ERR_ALIGN  = 2'b01;
   localparam logic [1:0] ERR_ACCESS = 2'b10;
   localparam logic [1:0] ERR_FUNCT3 = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_WAIT,
      S_DONE
   } lsu_state_t;

   function automatic logic f3_illegal(
      input logic       we,
      input logic [2:0] f3
   );
      if (we)
         return f3 > F3_SW;
      return (f3 == 3'b011) || (f3 == 3'b110) ||
             (f3 == 3'b111);
   endfunction

   // Size lives in f3[1:0] for both signed and unsigned loads.
   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] lo
   );
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory and response signals of the load/store unit.
// The unit uses the slave view; its environment uses master.
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;

   modport slave (
      input  req_valid, req_we, req_funct3,
      input  req_addr, req_wdata,
      input  mem_rvalid, mem_rdata, rsp_ready,
      output req_ready,
      output mem_req, mem_we, mem_addr,
      output mem_be, mem_wdata,
      output rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output req_valid, req_we, req_funct3,
      output req_addr, req_wdata,
      output mem_rvalid, mem_rdata, rsp_ready,
      input  req_ready,
      input  mem_req, mem_we, mem_addr,
      input  mem_be, mem_wdata,
      input  rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Store lane replication / byte enables and load byte or
// half extraction with sign or zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
   assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      be      = 4'b1111;
      wdata_o = '0;
      rdata_o = rdata;
      if (we) begin
         unique case (funct3)
            F3_SB: begin
               be      = 4'b0001 << addr_lo;
               wdata_o = {4{wdata[7:0]}};
            end
            F3_SH: begin
               be      = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{wdata[15:0]}};
            end
            default: wdata_o = wdata;
         endcase
      end else begin
         unique case (funct3)
            F3_LB:  rdata_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:  rdata_o = {{16{half_v[15]}}, half_v};
            F3_LBU: rdata_o = {24'h0, byte_v};
            F3_LHU: rdata_o = {16'h0, half_v};
            default: rdata_o = rdata;
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request checks, one-shot memory
// strobe, bounded wait for completion and a held response.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES      = 1024,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input logic                clk,
   input logic                rst,
   load_store_unit_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 1);

   lsu_state_t       state;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [1:0]       lo_q;
   logic [CNT_W-1:0] cnt;

   logic        req_ready_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;
   logic [1:0]  rsp_err_q;

   logic        idle;
   logic        la_we;
   logic [2:0]  la_f3;
   logic [1:0]  la_lo;
   logic [3:0]  la_be;
   logic [31:0] la_wdata;
   logic [31:0] la_rdata;
   logic [1:0]  req_err;

   // Steering sees the live request while idle, and the
   // captured request afterwards for load extraction.
   assign idle  = state == S_IDLE;
   assign la_we = idle ? bus.req_we : we_q;
   assign la_f3 = idle ? bus.req_funct3 : f3_q;
   assign la_lo = idle ? bus.req_addr[1:0] : lo_q;

   lsu_lane_align u_align (
      .we      (la_we),
      .funct3  (la_f3),
      .addr_lo (la_lo),
      .wdata   (bus.req_wdata),
      .rdata   (bus.mem_rdata),
      .be      (la_be),
      .wdata_o (la_wdata),
      .rdata_o (la_rdata)
   );

   always_comb begin
      req_err = ERR_OK;
      if (f3_illegal(bus.req_we, bus.req_funct3))
         req_err = ERR_FUNCT3;
      else if (misaligned(bus.req_funct3,
                          bus.req_addr[1:0]))
         req_err = ERR_ALIGN;
      else if (bus.req_addr > ADDR_MAX)
         req_err = ERR_ACCESS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         we_q        <= 1'b0;
         f3_q        <= '0;
         lo_q        <= '0;
         cnt         <= '0;
         req_ready_q <= 1'b1;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= ERR_OK;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  we_q        <= bus.req_we;
                  f3_q        <= bus.req_funct3;
                  lo_q        <= bus.req_addr[1:0];
                  req_ready_q <= 1'b0;
                  if (req_err != ERR_OK) begin
                     state       <= S_DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= req_err;
                     rsp_data_q  <= '0;
                  end else begin
                     state       <= S_ACCESS;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= bus.req_we;
                     mem_addr_q  <= {bus.req_addr[31:2],
                                     2'b00};
                     mem_be_q    <= la_be;
                     mem_wdata_q <= la_wdata;
                  end
               end
            end
            S_ACCESS: begin
               state       <= S_WAIT;
               cnt         <= '0;
               mem_req_q   <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_be_q    <= '0;
               mem_wdata_q <= '0;
            end
            S_WAIT: begin
               // Completion beats timeout in the last cycle.
               if (bus.mem_rvalid) begin
                  state       <= S_DONE;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= ERR_OK;
                  rsp_data_q  <= we_q ? '0 : la_rdata;
               end else if (cnt == CNT_LAST) begin
                  state       <= S_DONE;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= ERR_ACCESS;
                  rsp_data_q  <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.rsp_ready) begin
                  state       <= S_IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= ERR_OK;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, load extension,
// error priority, timeout, back-pressure and reset abandon.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   load_store_unit_if bus ();

   load_store_unit #(
      .MEM_BYTES      (1024),
      .TIMEOUT_CYCLES (16),
      .CNT_W          (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   task automatic send_req(
      input logic        we,
      input logic [2:0]  f3,
      input logic [31:0] a,
      input logic [31:0] d
   );
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL req_ready_wait got=%b exp=1",
                  bus.req_ready);
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      @(posedge clk); #1;
      bus.req_valid  = 1'b0;
   endtask

   task automatic pulse_rvalid(input logic [31:0] rd);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rd;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
   endtask

   task automatic retire();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   // Leaves the bench at mid-cycle with the response showing.
   task automatic load_once(
      input logic [2:0]  f3,
      input logic [31:0] a,
      input logic [31:0] rd
   );
      send_req(1'b0, f3, a, 32'h0);
      @(posedge clk); #1;
      pulse_rvalid(rd);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_req_ready got=%b exp=1",
                  bus.req_ready);
      end
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_be,
           bus.mem_addr, bus.mem_wdata} !== '0) begin
         failures++;
         $display("FAIL rst_mem got=%b/%h/%h exp=0",
                  bus.mem_req, bus.mem_be, bus.mem_addr);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data}
          !== '0) begin
         failures++;
         $display("FAIL rst_rsp got=%b/%b/%h exp=0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_store_word();
      send_req(1'b1, F3_SW, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11) begin
         failures++;
         $display("FAIL sw_strobe got=%b%b exp=11",
                  bus.mem_req, bus.mem_we);
      end
      checks++;
      if (bus.mem_addr !== 32'h10 ||
          bus.mem_be !== 4'b1111 ||
          bus.mem_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL sw_bus got=%h/%b/%h exp=10/1111/deadbeef",
                  bus.mem_addr, bus.mem_be, bus.mem_wdata);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_addr, bus.rsp_valid}
          !== '0) begin
         failures++;
         $display("FAIL sw_wait got=%b/%h/%b exp=0/0/0",
                  bus.mem_req, bus.mem_addr, bus.rsp_valid);
      end
      pulse_rvalid(32'h5555_5555);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== ERR_OK ||
          bus.rsp_data !== 32'h0) begin
         failures++;
         $display("FAIL sw_rsp got=%b/%b/%h exp=1/00/0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      retire();
   endtask

   task automatic test_store_sub();
      send_req(1'b1, F3_SB, 32'h13, 32'h000000A5);
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 32'h10 ||
          bus.mem_be !== 4'b1000 ||
          bus.mem_wdata !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL sb_bus got=%h/%b/%h exp=10/1000/a5a5a5a5",
                  bus.mem_addr, bus.mem_be, bus.mem_wdata);
      end
      @(posedge clk); #1;
      pulse_rvalid(32'h0);
      retire();
      send_req(1'b1, F3_SH, 32'h12, 32'hFFFF1234);
      @(negedge clk);
      checks++;
      if (bus.mem_addr !== 32'h10 ||
          bus.mem_be !== 4'b1100 ||
          bus.mem_wdata !== 32'h12341234) begin
         failures++;
         $display("FAIL sh_bus got=%h/%b/%h exp=10/1100/12341234",
                  bus.mem_addr, bus.mem_be, bus.mem_wdata);
      end
      @(posedge clk); #1;
      pulse_rvalid(32'h0);
      retire();
   endtask

   task automatic test_load_ext();
      send_req(1'b0, F3_LB, 32'h22, 32'hFFFFFFFF);
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 ||
          bus.mem_be !== 4'b1111 ||
          bus.mem_addr !== 32'h20 ||
          bus.mem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL lb_bus got=%b%b/%b/%h/%h exp=10/1111/20/0",
                  bus.mem_req, bus.mem_we, bus.mem_be,
                  bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk); #1;
      pulse_rvalid(32'h12F07834);
      @(negedge clk);
      checks++;
      if (bus.rsp_data !== 32'hFFFFFFF0 ||
          bus.rsp_err !== ERR_OK) begin
         failures++;
         $display("FAIL lb_data got=%h/%b exp=fffffff0/00",
                  bus.rsp_data, bus.rsp_err);
      end
      retire();
      load_once(F3_LBU, 32'h22, 32'h12F07834);
      checks++;
      if (bus.rsp_data !== 32'h000000F0) begin
         failures++;
         $display("FAIL lbu_data got=%h exp=000000f0",
                  bus.rsp_data);
      end
      retire();
      load_once(F3_LHU, 32'h22, 32'h12F07834);
      checks++;
      if (bus.rsp_data !== 32'h000012F0) begin
         failures++;
         $display("FAIL lhu_data got=%h exp=000012f0",
                  bus.rsp_data);
      end
      retire();
      load_once(F3_LH, 32'h20, 32'h00008001);
      checks++;
      if (bus.rsp_data !== 32'hFFFF8001) begin
         failures++;
         $display("FAIL lh_data got=%h exp=ffff8001",
                  bus.rsp_data);
      end
      retire();
      load_once(F3_LW, 32'h3FC, 32'h89ABCDEF);
      checks++;
      if (bus.rsp_data !== 32'h89ABCDEF ||
          bus.rsp_err !== ERR_OK) begin
         failures++;
         $display("FAIL lw_data got=%h/%b exp=89abcdef/00",
                  bus.rsp_data, bus.rsp_err);
      end
      retire();
   endtask

   task automatic test_errors();
      logic [1:0]  exp_err [4];
      logic        e_we    [4];
      logic [2:0]  e_f3    [4];
      logic [31:0] e_addr  [4];
      e_we[0] = 1'b0; e_f3[0] = F3_LW;  e_addr[0] = 32'h06;
      exp_err[0] = ERR_ALIGN;
      e_we[1] = 1'b0; e_f3[1] = 3'b110; e_addr[1] = 32'h07;
      exp_err[1] = ERR_FUNCT3;
      e_we[2] = 1'b0; e_f3[2] = F3_LW;  e_addr[2] = 32'h400;
      exp_err[2] = ERR_ACCESS;
      e_we[3] = 1'b1; e_f3[3] = 3'b100; e_addr[3] = 32'h0;
      exp_err[3] = ERR_FUNCT3;
      for (int i = 0; i < 4; i++) begin
         send_req(e_we[i], e_f3[i], e_addr[i], 32'hFFFFFFFF);
         @(negedge clk);
         checks++;
         if (bus.mem_req !== 1'b0 || bus.rsp_valid !== 1'b1 ||
             bus.rsp_err !== exp_err[i] ||
             bus.rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL err_%0d got=%b/%b/%b/%h exp=0/1/%b/0",
                     i, bus.mem_req, bus.rsp_valid,
                     bus.rsp_err, bus.rsp_data, exp_err[i]);
         end
         retire();
      end
   endtask

   task automatic test_timeout();
      send_req(1'b0, F3_LW, 32'h0, 32'h0);
      repeat (16) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_early got=%b exp=0", bus.rsp_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 ||
          bus.rsp_err !== ERR_ACCESS ||
          bus.rsp_data !== 32'h0) begin
         failures++;
         $display("FAIL to_fault got=%b/%b/%h exp=1/10/0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      retire();
      send_req(1'b0, F3_LW, 32'h0, 32'h0);
      repeat (16) begin
         @(posedge clk); #1;
      end
      pulse_rvalid(32'hCAFEF00D);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== ERR_OK ||
          bus.rsp_data !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL to_last got=%b/%b/%h exp=1/00/cafef00d",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      retire();
   endtask

   task automatic test_back_to_back();
      load_once(F3_LW, 32'h40, 32'h11223344);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 ||
             bus.rsp_data !== 32'h11223344 ||
             bus.rsp_err !== ERR_OK ||
             bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_%0d got=%b/%h/%b/%b exp=1/11223344/00/0",
                     i, bus.rsp_valid, bus.rsp_data,
                     bus.rsp_err, bus.req_ready);
         end
         @(negedge clk);
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = F3_LW;
      bus.req_addr   = 32'h44;
      bus.rsp_ready  = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready  = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
          bus.mem_req !== 1'b0) begin
         failures++;
         $display("FAIL retire_gap got=%b/%b/%b exp=1/0/0",
                  bus.req_ready, bus.rsp_valid, bus.mem_req);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h44) begin
         failures++;
         $display("FAIL b2b_accept got=%b/%h exp=1/44",
                  bus.mem_req, bus.mem_addr);
      end
      @(posedge clk); #1;
      pulse_rvalid(32'h0);
      retire();
   endtask

   task automatic test_reset_mid();
      send_req(1'b0, F3_LW, 32'h8, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0 ||
          bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_async got=%b/%b/%b exp=1/0/0",
                  bus.req_ready, bus.mem_req, bus.rsp_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      pulse_rvalid(32'hFFFFFFFF);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.mem_req !== 1'b0 || bus.rsp_data !== 32'h0) begin
         failures++;
         $display("FAIL rst_late got=%b/%b/%b/%h exp=0/1/0/0",
                  bus.rsp_valid, bus.req_ready, bus.mem_req,
                  bus.rsp_data);
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      bus.rsp_ready  = 1'b0;
      test_reset();
      test_store_word();
      test_store_sub();
      test_load_ext();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
